// File: rtl/counter_checker_if.sv
// Serial receive stream into the counter checker: one data bit plus its qualifier.
interface counter_checker_if;
    logic data_in;
    logic valid_in;

    modport master (output data_in, output valid_in);
    modport slave  (input  data_in, input  valid_in);
endinterface

// File: rtl/counter_checker.sv
// Counter-pattern checker: compares a received serial stream against an
// incrementing 8-bit symbol sequence (LSB first), counting bit and frame
// errors over N_PCS frames of RS_K*RS_SYMBOL_WIDTH information bits.
module counter_checker #(
    parameter logic [63:0] SEED            = 64'h0000000000000001,
    parameter int          RS_K            = 60,
    parameter int          RS_N            = 68,
    parameter int          RS_SYMBOL_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic [31:0]               N_PCS,
    counter_checker_if.slave          rx,
    output logic [31:0]               bits_checked,
    output logic [31:0]               bit_errors,
    output logic [31:0]               frames_checked,
    output logic [31:0]               frame_errors,
    output logic                      err_pulse,
    output logic                      done
);

    localparam int          INFO_BITS = RS_K * RS_SYMBOL_WIDTH;
    localparam logic [31:0] LAST_BIT  = 32'(INFO_BITS - 1);

    // SEED and RS_N only exist so the checker drops in beside the generator;
    // reject a configuration where the codeword is shorter than its payload.
    if (RS_N < RS_K || $bits(SEED) != 64) begin : g_bad_cfg
        $error("counter_checker: RS_N must be >= RS_K");
    end

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] n_lat;
    logic [7:0]  exp_sym;
    logic [2:0]  bit_idx;
    logic [31:0] frame_bit_cnt;
    logic        frame_flag;

    logic        accept;
    logic        mismatch;
    logic        frame_end;
    logic [31:0] target;
    logic [31:0] frames_next;

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    assign mismatch    = accept && (rx.data_in != exp_sym[bit_idx]);
    assign frame_end   = accept && (frame_bit_cnt == LAST_BIT);
    assign frames_next = sat_inc(frames_checked);
    // The frame target comes straight from the port on the starting cycle.
    assign target      = (state == IDLE) ? N_PCS : n_lat;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and bit-acceptance decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (N_PCS == 32'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = CHECK;
                        accept     = rx.valid_in;
                    end
                end
            end
            CHECK: accept = en && rx.valid_in;
            default: state_next = DONE;
        endcase
        if (frame_end && frames_next == target) state_next = DONE;
    end

    // Frame count target, captured once when checking starts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                     n_lat <= 32'd0;
        else if (state == IDLE && en && N_PCS != 32'd0) n_lat <= N_PCS;
    end

    // Expected-pattern position and per-frame bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_sym       <= 8'd0;
            bit_idx       <= 3'd0;
            frame_bit_cnt <= 32'd0;
            frame_flag    <= 1'b0;
        end else if (accept) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) exp_sym <= exp_sym + 8'd1;
            if (frame_end) begin
                frame_bit_cnt <= 32'd0;
                frame_flag    <= 1'b0;
            end else begin
                frame_bit_cnt <= frame_bit_cnt + 32'd1;
                frame_flag    <= frame_flag | mismatch;
            end
        end
    end

    // Saturating result counters, error strobe and done flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bits_checked   <= 32'd0;
            bit_errors     <= 32'd0;
            frames_checked <= 32'd0;
            frame_errors   <= 32'd0;
            err_pulse      <= 1'b0;
            done           <= 1'b0;
        end else begin
            err_pulse <= mismatch;
            done      <= (state_next == DONE);
            if (accept) begin
                bits_checked <= sat_inc(bits_checked);
                if (mismatch) bit_errors <= sat_inc(bit_errors);
                if (frame_end) begin
                    frames_checked <= frames_next;
                    if (frame_flag || mismatch) frame_errors <= sat_inc(frame_errors);
                end
            end
        end
    end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 SHALL have parameter SEED, default 64'h0000000000000001; unused, kept for generator-interface compatibility.
REQ-002 SHALL have parameter RS_K, default 60; RS information symbols per frame.
REQ-003 SHALL have parameter RS_N, default 68; RS codeword length; unused by the check logic.
REQ-004 SHALL have parameter RS_SYMBOL_WIDTH, default 8; bits per symbol; INFO_BITS = RS_K*RS_SYMBOL_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit; the single clock; all state is on the rising edge.
REQ-006 SHALL have port rstn, input, 1 bit; reset, asynchronous and active-low.
REQ-007 SHALL have port en, input, 1 bit; check enable.
REQ-008 SHALL have port N_PCS, input, 32 bits; number of frames to check.
REQ-009 SHALL have port data_in, input, 1 bit; received serial data bit.
REQ-010 SHALL have port valid_in, input, 1 bit; data_in qualifier.
REQ-011 SHALL have port bits_checked, output, 32 bits; count of accepted bits.
REQ-012 SHALL have port bit_errors, output, 32 bits; count of mismatched bits.
REQ-013 SHALL have port frames_checked, output, 32 bits; count of completed frames.
REQ-014 SHALL have port frame_errors, output, 32 bits; count of frames containing at least one error.
REQ-015 SHALL have port err_pulse, output, 1 bit; one-cycle mismatch strobe.
REQ-016 SHALL have port done, output, 1 bit; high when all N_PCS frames are checked.

Function
REQ-017 SHALL implement FSM states IDLE, CHECK and DONE.
REQ-018 IDLE, en=1, N_PCS!=0 -> CHECK: SHALL latch N_PCS into n_lat, and SHALL check that cycle's bit if valid_in=1.
REQ-019 IDLE, en=1, N_PCS=0 -> DONE on the next edge, with no bits checked.
REQ-020 SHALL treat a bit as accepted only when state is IDLE or CHECK, en=1 and valid_in=1; cycles with en=0 or valid_in=0 SHALL hold all state.
REQ-021 SHALL form the expected bit as exp_sym[bit_idx], where exp_sym is an 8-bit symbol counter starting at 0 and bit_idx is 0..7, LSB first.
REQ-022 SHALL wrap bit_idx 7->0 on each accepted bit and increment exp_sym by 1 mod 256 on that wrap (255->0).
REQ-023 SHALL carry exp_sym across frame boundaries and SHALL NOT reset it per frame.
REQ-024 On an accepted bit: bits_checked +1; if data_in != expected bit, bit_errors +1, err_pulse=1 for exactly the following cycle, and the per-frame error flag is set.
REQ-025 SHALL complete a frame on the INFO_BITS-th accepted bit of the frame (gaps in valid_in are irrelevant).
REQ-026 On frame completion: frames_checked +1; frame_errors +1 if the frame flag is set or the final bit mismatches; the frame flag clears.
REQ-027 SHALL transition CHECK -> DONE on the edge where frames_checked reaches n_lat.
REQ-028 In DONE: done=1, valid_in ignored, all counters frozen; done SHALL be held until rstn is asserted.
REQ-029 SHALL saturate every 32-bit counter at 32'hFFFFFFFF with no wrap.
REQ-030 All outputs SHALL be registered; counters and err_pulse SHALL reflect an accepted bit one cycle after acceptance.
REQ-031 SHALL ignore changes to N_PCS after latching until the next reset.

Reset
REQ-032 rstn=0 SHALL immediately, without a clock edge, force state=IDLE, exp_sym=0, bit_idx=0, the frame flag=0, all counters=0, err_pulse=0 and done=0.
REQ-033 Reset mid-frame SHALL discard the partial frame; after rstn releases, checking SHALL restart from symbol 0, bit 0.
REQ-034 SHALL restart checking only through rstn; there is no other restart mechanism.

Verification
REQ-035 Loopback from the counter generator, RS_K=60, N_PCS=2 -> bits_checked=960, bit_errors=0, frames_checked=2, frame_errors=0, done=1.
REQ-036 Invert the first accepted bit (expected 0, drive 1), N_PCS=1 -> bit_errors=1, frame_errors=1, err_pulse high exactly one cycle, done=1.
REQ-037 N_PCS=5, clean stream -> frame 4 starts at symbol 240, wraps 255->0 and ends at 43; bit_errors=0; frames_checked=5.
REQ-038 N_PCS=3, then keep driving valid_in=1 after done -> bits_checked stays 1440 and done stays 1.
REQ-039 Drop rstn asynchronously at bit 100, then replay from symbol 0 with N_PCS=1 -> outputs clear before the next edge; final bits_checked=480, bit_errors=0.
REQ-040 N_PCS=0, en=1 -> done=1 after one edge; all counters remain 0.
